display_update_controller: RTL and testbench

- Sequencer that feeds the 4-digit multiplexed 7-segment display path.
- Arbitrates between two signed binary sources: the multiplier result and the operand echo. The result has fixed priority.
- Converts the granted value to sign plus 3-digit BCD with a sequential double-dabble engine.
- Holds the registered BCD_code, sign and overflow that drive the display multiplexer until the next update.

---
 rtl/display_update_controller.sv | 108 ++++++++++
 tb/tb_display_update_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/display_update_controller.sv
// Arbitrates result/operand values and converts the granted one to sign + 3-digit BCD via sequential double-dabble.
// Display registers update W+1 cycles after acceptance; no input is accepted while a conversion is running.
module display_update_controller #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic         res_ready,
  input  logic         opd_valid,
  input  logic [W-1:0] opd_data,
  output logic         opd_ready,
  output logic [11:0]  BCD_code,
  output logic         sign,
  output logic         overflow,
  output logic         src_sel,
  output logic         busy,
  output logic         update_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state_q;
  logic [W-1:0] mag_q;
  logic [15:0]  scr_q;
  logic [3:0]   cnt_q;
  logic         psign_q, psrc_q;
  logic [11:0]  bcd_q;
  logic         sign_q, ovf_q, src_q, upd_q;

  logic         take_res, take_opd;
  logic [W-1:0] in_dat, mag_d;
  logic [15:0]  adj_d;

  always_comb begin
    res_ready = (state_q == IDLE) && !reset;
    opd_ready = res_ready && !res_valid;
    take_res  = res_valid && res_ready;
    take_opd  = opd_valid && opd_ready;
    in_dat    = take_res ? res_data : opd_data;
    // W-bit negate maps -2^(W-1) onto the unsigned value 2^(W-1)
    mag_d     = in_dat[W-1] ? (~in_dat + W'(1)) : in_dat;
    adj_d     = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      psign_q  <= 1'b0;
      psrc_q   <= 1'b0;
      bcd_q    <= 12'h000;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      src_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_res || take_opd) begin
            psrc_q  <= take_res;
            psign_q <= in_dat[W-1];
            mag_q   <= mag_d;
            scr_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= {adj_d[14:0], mag_q[W-1]};
          mag_q <= {mag_q[W-2:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(W-1)) state_q <= DONE;
        end
        DONE: begin
          // A non-zero thousands digit saturates the 3-digit display
          if (scr_q[15:12] != 4'd0) begin
            bcd_q <= 12'h999;
            ovf_q <= 1'b1;
          end else begin
            bcd_q <= scr_q[11:0];
            ovf_q <= 1'b0;
          end
          sign_q  <= psign_q;
          src_q   <= psrc_q;
          upd_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BCD_code    = bcd_q;
  assign sign        = sign_q;
  assign overflow    = ovf_q;
  assign src_sel     = src_q;
  assign busy        = (state_q != IDLE);
  assign update_done = upd_q;

endmodule

// File: tb/tb_display_update_controller.sv
// Directed and exhaustive checks of display_update_controller at W = 11.
module tb_display_update_controller;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset;
  logic         res_valid, opd_valid;
  logic [W-1:0] res_data, opd_data;
  logic         res_ready, opd_ready;
  logic [11:0]  BCD_code;
  logic         sign, overflow, src_sel, busy, update_done;

  int tests = 0;
  int fails = 0;

  display_update_controller #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .opd_valid(opd_valid), .opd_data(opd_data), .opd_ready(opd_ready),
    .BCD_code(BCD_code), .sign(sign), .overflow(overflow),
    .src_sel(src_sel), .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the acceptance edge; returns cycles until update_done.
  task automatic wait_done(output int cyc, output logic busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (update_done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1 || res_ready !== 1'b0 || opd_ready !== 1'b0) busy_ok = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic send_res(input logic [W-1:0] d, output int cyc, output logic busy_ok);
    res_data  = d;
    res_valid = 1'b1;
    #1;
    check("res_ready_idle", res_ready, 1);
    step();
    res_valid = 1'b0;
    res_data  = W'($urandom);
    wait_done(cyc, busy_ok);
  endtask

  task automatic ref_model(input logic [W-1:0] d, output logic [11:0] bcd,
                           output logic s, output logic ov);
    logic signed [W-1:0] sd;
    int v, m;
    sd = d;
    v  = sd;
    s  = (v < 0);
    m  = (v < 0) ? -v : v;
    ov = (m > 999);
    if (ov) bcd = 12'h999;
    else    bcd = 12'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
  endtask

  initial begin
    int          cyc;
    logic        bok;
    logic [11:0] eb;
    logic        es, eo;

    reset = 1'b1; res_valid = 1'b0; opd_valid = 1'b0; res_data = '0; opd_data = '0;
    step(); step();
    check("rst_bcd", BCD_code, 12'h000);
    check("rst_flags", {sign, overflow, src_sel, busy, update_done}, 5'b0);
    check("rst_ready", {res_ready, opd_ready}, 2'b00);
    reset = 1'b0;
    step();
    check("idle_ready", {res_ready, opd_ready}, 2'b11);

    // +56 from result channel
    send_res(W'(56), cyc, bok);
    check("p56_latency", cyc, 12);
    check("p56_busy", bok, 1);
    check("p56_bcd", BCD_code, 12'h056);
    check("p56_flags", {sign, overflow, src_sel}, 3'b001);
    step();
    check("p56_pulse", update_done, 0);
    check("p56_hold", BCD_code, 12'h056);

    send_res(W'(-123), cyc, bok);
    check("m123", {BCD_code, sign, overflow}, {12'h123, 2'b10});

    // zero on operand channel
    opd_data = '0; opd_valid = 1'b1;
    step();
    opd_valid = 1'b0;
    wait_done(cyc, bok);
    check("z_latency", cyc, 12);
    check("z_out", {BCD_code, sign, overflow, src_sel}, {12'h000, 3'b000});

    // simultaneous requests: result has priority, operand waits
    res_data = W'(7); res_valid = 1'b1;
    opd_data = W'(-4); opd_valid = 1'b1;
    #1;
    check("prio_ready", {res_ready, opd_ready}, 2'b10);
    step();
    res_valid = 1'b0;
    wait_done(cyc, bok);
    check("prio_busy", bok, 1);
    check("prio_first", {BCD_code, sign, src_sel}, {12'h007, 2'b01});
    check("prio_opd_ready", opd_ready, 1);
    step();
    opd_valid = 1'b0;
    wait_done(cyc, bok);
    check("prio_second_lat", cyc, 12);
    check("prio_second", {BCD_code, sign, overflow, src_sel}, {12'h004, 3'b100});

    // boundaries
    send_res(W'(999), cyc, bok);
    check("b999", {BCD_code, sign, overflow}, {12'h999, 2'b00});
    send_res(W'(1000), cyc, bok);
    check("b1000", {BCD_code, sign, overflow}, {12'h999, 2'b01});
    send_res(W'(-1024), cyc, bok);
    check("bm1024", {BCD_code, sign, overflow}, {12'h999, 2'b11});
    send_res(W'(1023), cyc, bok);
    check("b1023", {BCD_code, sign, overflow}, {12'h999, 2'b01});

    // reset in the middle of a conversion
    send_res(W'(42), cyc, bok);
    check("pre42", BCD_code, 12'h042);
    res_data = W'(851); res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    repeat (5) step();
    check("mid_hold", {BCD_code, busy, update_done}, {12'h042, 2'b10});
    reset = 1'b1;
    #1;
    check("arst_bcd", BCD_code, 12'h000);
    check("arst_flags", {sign, overflow, src_sel, busy, update_done}, 5'b0);
    check("arst_ready", {res_ready, opd_ready}, 2'b00);
    step(); step();
    check("arst_nopulse", update_done, 0);
    reset = 1'b0;
    step();
    check("post_rst", {BCD_code, update_done, busy}, {12'h000, 2'b00});
    send_res(W'(851), cyc, bok);
    check("p851", {BCD_code, sign, overflow}, {12'h851, 2'b00});

    // exhaustive sweep on the result channel
    for (int i = 0; i < (1 << W); i++) begin
      send_res(W'(i), cyc, bok);
      ref_model(W'(i), eb, es, eo);
      check("sweep_out", {BCD_code, sign, overflow, src_sel}, {eb, es, eo, 1'b1});
      check("sweep_latency", cyc, W + 1);
      check("sweep_busy", bok, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
